// File: rtl/fetch_latency_tracker_pkg.sv
// rtl/fetch_latency_tracker_pkg.sv - shared constants and types for the fetch-to-commit latency tracker
package fetch_latency_tracker_pkg;

    localparam int FETCH_LAT_CNT_WIDTH    = 32;
    localparam int FETCH_LAT_QUEUE_DEPTH  = 16;
    localparam int FETCH_LAT_HIST_BUCKETS = 8;
    localparam int FETCH_LAT_PTR_WIDTH    = $clog2(FETCH_LAT_QUEUE_DEPTH);

    typedef logic [FETCH_LAT_CNT_WIDTH-1:0] fetch_latency_count_t;
    typedef logic [FETCH_LAT_PTR_WIDTH-1:0] fetch_lat_ptr_t;
    typedef logic [FETCH_LAT_PTR_WIDTH:0]   fetch_lat_occ_t;

endpackage

// File: rtl/fetch_latency_tracker_if.sv
// rtl/fetch_latency_tracker_if.sv - fetch/commit event and statistics bundle; latency_hist present under FETCH_LATENCY_HISTOGRAM_EN
interface fetch_latency_tracker_if
    import fetch_latency_tracker_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int CNT_WIDTH   = FETCH_LAT_CNT_WIDTH
) ();

    logic                   fetch_valid;
    logic [FETCH_WIDTH-1:0] fetch_hit;
    logic                   commit_pop;
    logic                   flush;
    logic [CNT_WIDTH-1:0]   cycle_counter;
    logic [CNT_WIDTH-1:0]   head_begin_cycle;
    logic [CNT_WIDTH-1:0]   latency_total;
    logic [CNT_WIDTH-1:0]   latency_max;
    logic [CNT_WIDTH-1:0]   group_count;
    logic                   full;
    logic                   empty;
    logic [CNT_WIDTH-1:0]   drop_count;
`ifdef FETCH_LATENCY_HISTOGRAM_EN
    logic [FETCH_LAT_HIST_BUCKETS-1:0][CNT_WIDTH-1:0] latency_hist;
`endif

    modport master (
        output fetch_valid, fetch_hit, commit_pop, flush,
        input  cycle_counter, head_begin_cycle, latency_total, latency_max,
               group_count, full, empty, drop_count
`ifdef FETCH_LATENCY_HISTOGRAM_EN
        , input latency_hist
`endif
    );

    modport slave (
        input  fetch_valid, fetch_hit, commit_pop, flush,
        output cycle_counter, head_begin_cycle, latency_total, latency_max,
               group_count, full, empty, drop_count
`ifdef FETCH_LATENCY_HISTOGRAM_EN
        , output latency_hist
`endif
    );

endinterface

// File: rtl/fetch_latency_queue.sv
// rtl/fetch_latency_queue.sv - circular tag FIFO holding begin cycles of in-flight fetch groups
module fetch_latency_queue #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    assign empty = (occupancy == '0);
    assign full  = (occupancy == (PTR_WIDTH+1)'(DEPTH));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10:   occupancy <= occupancy + (PTR_WIDTH+1)'(1);
                2'b01:   occupancy <= occupancy - (PTR_WIDTH+1)'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_latency_tracker.sv
// rtl/fetch_latency_tracker.sv - fetch-to-commit latency statistics; log2 histogram under FETCH_LATENCY_HISTOGRAM_EN
module fetch_latency_tracker
    import fetch_latency_tracker_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int QUEUE_DEPTH = FETCH_LAT_QUEUE_DEPTH,
    parameter int CNT_WIDTH   = FETCH_LAT_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    fetch_latency_tracker_if.slave  bus
);

    localparam int OCC_WIDTH = $clog2(QUEUE_DEPTH) + 1;

    logic [CNT_WIDTH-1:0]   cycle_counter;
    logic [CNT_WIDTH-1:0]   latency_total;
    logic [CNT_WIDTH-1:0]   latency_max;
    logic [CNT_WIDTH-1:0]   group_count;
    logic [CNT_WIDTH-1:0]   drop_count;
    logic [CNT_WIDTH-1:0]   q_head;
    logic [CNT_WIDTH-1:0]   latency;
    logic [CNT_WIDTH:0]     total_sum;
    logic [FETCH_WIDTH-1:0] lane_hit;
    logic [OCC_WIDTH-1:0]   q_occupancy;
    logic                   q_full;
    logic                   q_empty;
    logic                   push_req;
    logic                   pop_ok;
    logic                   drop;

    assign lane_hit = bus.fetch_hit;
    assign push_req = bus.fetch_valid && (|lane_hit) && !bus.flush;
    assign pop_ok   = bus.commit_pop && !q_empty && !bus.flush;
    assign drop     = push_req && q_full && !pop_ok;

    // Modular subtraction keeps the latency correct across a counter wrap.
    assign latency   = cycle_counter - q_head;
    assign total_sum = {1'b0, latency_total} + {1'b0, latency};

    fetch_latency_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (CNT_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .pop       (bus.commit_pop),
        .flush     (bus.flush),
        .push_data (cycle_counter),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .occupancy (q_occupancy)
    );

    assert property (@(posedge clk) disable iff (rst) q_occupancy <= OCC_WIDTH'(QUEUE_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_counter <= '0;
            latency_total <= '0;
            latency_max   <= '0;
            group_count   <= '0;
            drop_count    <= '0;
        end else begin
            cycle_counter <= cycle_counter + CNT_WIDTH'(1);
            if (drop && !(&drop_count))
                drop_count <= drop_count + CNT_WIDTH'(1);
            if (pop_ok) begin
                latency_total <= total_sum[CNT_WIDTH] ? '1 : total_sum[CNT_WIDTH-1:0];
                if (!(&group_count))
                    group_count <= group_count + CNT_WIDTH'(1);
                if (latency > latency_max)
                    latency_max <= latency;
            end
        end
    end

`ifdef FETCH_LATENCY_HISTOGRAM_EN
    localparam int HIDX_WIDTH = $clog2(FETCH_LAT_HIST_BUCKETS);

    logic [FETCH_LAT_HIST_BUCKETS-1:0][CNT_WIDTH-1:0] latency_hist;
    logic [HIDX_WIDTH-1:0]                            hist_idx;

    // Bucket = floor(log2(latency)), with 0 folded into bucket 0 and the top bucket open-ended.
    always_comb begin
        hist_idx = '0;
        for (int k = 1; k < FETCH_LAT_HIST_BUCKETS; k++) begin
            if (latency >= (CNT_WIDTH'(1) << k))
                hist_idx = HIDX_WIDTH'(k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            latency_hist <= '0;
        else if (pop_ok && !(&latency_hist[hist_idx]))
            latency_hist[hist_idx] <= latency_hist[hist_idx] + CNT_WIDTH'(1);
    end

    assign bus.latency_hist = latency_hist;
`endif

    assign bus.cycle_counter    = cycle_counter;
    assign bus.head_begin_cycle = q_empty ? '0 : q_head;
    assign bus.latency_total    = latency_total;
    assign bus.latency_max      = latency_max;
    assign bus.group_count      = group_count;
    assign bus.drop_count       = drop_count;
    assign bus.full             = q_full;
    assign bus.empty            = q_empty;

endmodule

// File: tb/tb_fetch_latency_tracker.sv
// tb/tb_fetch_latency_tracker.sv - directed self-checking bench: 32-bit instance for queue behaviour, 8-bit instance for wrap/saturation/histogram
module tb_fetch_latency_tracker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    fetch_latency_tracker_if #(.FETCH_WIDTH(2), .CNT_WIDTH(32)) b ();
    fetch_latency_tracker_if #(.FETCH_WIDTH(2), .CNT_WIDTH(8))  s ();

    fetch_latency_tracker #(.FETCH_WIDTH(2), .QUEUE_DEPTH(16), .CNT_WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    fetch_latency_tracker #(.FETCH_WIDTH(2), .QUEUE_DEPTH(16), .CNT_WIDTH(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_b(input logic [31:0] t);
        int n = 0;
        while (b.cycle_counter !== t && n < 600) begin
            tick();
            n++;
        end
        check("wait_b_counter", b.cycle_counter, t);
    endtask

    task automatic wait_s(input logic [7:0] t);
        int n = 0;
        while (s.cycle_counter !== t && n < 600) begin
            tick();
            n++;
        end
        check("wait_s_counter", {24'd0, s.cycle_counter}, {24'd0, t});
    endtask

    task automatic s_retire(input int lat);
        s.fetch_valid = 1'b1;
        s.fetch_hit   = 2'b10;
        tick();
        s.fetch_valid = 1'b0;
        repeat ((lat + 255) % 256) tick();
        s.commit_pop = 1'b1;
        tick();
        s.commit_pop = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

`ifdef FETCH_LATENCY_HISTOGRAM_EN
    logic [7:0] hist_exp [8];
`endif

    initial begin
        b.fetch_valid = 1'b0; b.fetch_hit = 2'b00; b.commit_pop = 1'b0; b.flush = 1'b0;
        s.fetch_valid = 1'b0; s.fetch_hit = 2'b00; s.commit_pop = 1'b0; s.flush = 1'b0;

        // reset state
        tick();
        tick();
        check("rst_cycle_counter", b.cycle_counter, 0);
        check("rst_head", b.head_begin_cycle, 0);
        check("rst_total", b.latency_total, 0);
        check("rst_max", b.latency_max, 0);
        check("rst_count", b.group_count, 0);
        check("rst_drop", b.drop_count, 0);
        check("rst_full", b.full, 0);
        check("rst_empty", b.empty, 1);
        check("rst_s_counter", s.cycle_counter, 0);
        check("rst_s_empty", s.empty, 1);
        rst = 1'b0;

        // single group: push at 10, commit at 15
        wait_b(10);
        b.fetch_valid = 1'b1; b.fetch_hit = 2'b01;
        tick();
        b.fetch_valid = 1'b0;
        check("single_head", b.head_begin_cycle, 10);
        check("single_not_empty", b.empty, 0);
        wait_b(15);
        b.commit_pop = 1'b1;
        tick();
        b.commit_pop = 1'b0;
        check("single_total", b.latency_total, 5);
        check("single_max", b.latency_max, 5);
        check("single_count", b.group_count, 1);
        check("single_empty", b.empty, 1);
        check("single_head_zero", b.head_begin_cycle, 0);

        // fill: pushes at counters 16..31, drop at 32, push+pop at 33
        check("fill_start_counter", b.cycle_counter, 16);
        b.fetch_valid = 1'b1; b.fetch_hit = 2'b11;
        repeat (16) tick();
        check("fill_full", b.full, 1);
        check("fill_head", b.head_begin_cycle, 16);
        check("fill_no_drop", b.drop_count, 0);
        tick();
        check("overflow_drop", b.drop_count, 1);
        check("overflow_full", b.full, 1);
        b.commit_pop = 1'b1;
        tick();
        b.commit_pop = 1'b0;
        b.fetch_valid = 1'b0;
        check("pushpop_full", b.full, 1);
        check("pushpop_drop", b.drop_count, 1);
        check("pushpop_count", b.group_count, 2);
        check("pushpop_total", b.latency_total, 22);
        check("pushpop_max", b.latency_max, 17);
        check("pushpop_head", b.head_begin_cycle, 17);

        // flush with simultaneous push and pop
        b.flush = 1'b1;
        tick();
        b.flush = 1'b0;
        check("flush_full_empty", b.empty, 1);
        check("flush_full_notfull", b.full, 0);
        b.fetch_valid = 1'b1; b.fetch_hit = 2'b10;
        repeat (3) tick();
        b.fetch_valid = 1'b0;
        check("three_head", b.head_begin_cycle, 35);
        b.flush = 1'b1; b.fetch_valid = 1'b1; b.commit_pop = 1'b1;
        tick();
        b.flush = 1'b0; b.fetch_valid = 1'b0; b.commit_pop = 1'b0;
        check("flush_empty", b.empty, 1);
        check("flush_total", b.latency_total, 22);
        check("flush_count", b.group_count, 2);
        check("flush_max", b.latency_max, 17);
        check("flush_drop", b.drop_count, 1);
        b.commit_pop = 1'b1;
        tick();
        b.commit_pop = 1'b0;
        check("empty_pop_count", b.group_count, 2);
        check("empty_pop_total", b.latency_total, 22);
        check("empty_pop_empty", b.empty, 1);

`ifdef FETCH_LATENCY_HISTOGRAM_EN
        s_retire(0);
        s_retire(1);
        s_retire(3);
        s_retire(200);
        hist_exp = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
        for (int k = 0; k < 8; k++)
            check($sformatf("hist_bucket%0d", k), {24'd0, s.latency_hist[k]}, {24'd0, hist_exp[k]});
        check("hist_count", s.group_count, 4);
`endif

        // wrap: push at 0xFE, pop at 0x03 on the 8-bit instance
        do_reset();
        wait_s(8'hFE);
        s.fetch_valid = 1'b1; s.fetch_hit = 2'b01;
        tick();
        s.fetch_valid = 1'b0;
        wait_s(8'h03);
        s.commit_pop = 1'b1;
        tick();
        s.commit_pop = 1'b0;
        check("wrap_total", s.latency_total, 5);
        check("wrap_max", s.latency_max, 5);
        check("wrap_count", s.group_count, 1);

        // saturation: bring total to 0xF0, then retire 0x20
        s_retire(235);
        check("sat_pre_total", s.latency_total, 8'hF0);
        s_retire(32);
        check("sat_total", s.latency_total, 8'hFF);
        check("sat_max", s.latency_max, 235);
        check("sat_count", s.group_count, 3);

        // reset mid-stream with active inputs
        b.fetch_valid = 1'b1; b.fetch_hit = 2'b01;
        repeat (5) tick();
        check("mid_not_empty", b.empty, 0);
        b.commit_pop = 1'b1;
        rst = 1'b1;
        tick();
        check("mid_rst_counter", b.cycle_counter, 0);
        check("mid_rst_head", b.head_begin_cycle, 0);
        check("mid_rst_total", b.latency_total, 0);
        check("mid_rst_max", b.latency_max, 0);
        check("mid_rst_count", b.group_count, 0);
        check("mid_rst_drop", b.drop_count, 0);
        check("mid_rst_full", b.full, 0);
        check("mid_rst_empty", b.empty, 1);
        check("mid_rst_s_total", s.latency_total, 0);
        rst = 1'b0;
        b.fetch_valid = 1'b0;
        b.commit_pop = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
